// File: rtl/axi_ram_slave.sv
// AXI4 slave bridging 8-byte INCR bursts onto a single-port-per-direction RAM.
// Write and read channels are handled by two independent state machines.
module axi_ram_slave #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic            awvalid,
    output logic            awready,
    input  logic [63:0]     wdata,
    input  logic [7:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [63:0]     rdata,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    output logic [63:0]     ram_wr_data,
    output logic [11:0]     ram_wr_addr,
    output logic            ram_wr_en,
    output logic [7:0]      ram_wr_mask,
    output logic [11:0]     ram_rd_addr,
    input  logic [63:0]     ram_rd_data
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic [11:0] w_idx;
    logic [7:0]  w_cnt;
    logic [7:0]  w_len;
    logic [11:0] r_idx;
    logic [11:0] r_idx_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  r_len;
    logic        unused_bits;

    // Burst length is counted from awlen, so wlast and sub-word address bits carry no information.
    assign unused_bits = ^{awaddr[31:15], awaddr[2:0], araddr[31:15], araddr[2:0], wlast};

    // RAM write port is gated so every output stays at zero outside a data phase.
    assign wready      = (w_state == W_DATA);
    assign ram_wr_en   = wready && wvalid;
    assign ram_wr_data = wready ? wdata : '0;
    assign ram_wr_mask = wready ? wstrb : '0;
    assign ram_wr_addr = wready ? w_idx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            w_idx   <= '0;
            w_cnt   <= '0;
            w_len   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        bid     <= awid;
                        w_idx   <= awaddr[14:3];
                        w_len   <= awlen;
                        w_cnt   <= '0;
                        awready <= 1'b0;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_idx <= w_idx + 12'd1;
                        w_cnt <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // While a beat is presented, the RAM already looks up the following word so it can load without a bubble.
    assign r_idx_nxt   = r_idx + 12'd1;
    assign ram_rd_addr = arready ? araddr[14:3] : ((r_state == R_DATA) ? r_idx_nxt : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rid     <= '0;
            rlast   <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rdata   <= ram_rd_data;
                        rid     <= arid;
                        rlast   <= (arlen == 8'd0);
                        rvalid  <= 1'b1;
                        r_idx   <= araddr[14:3];
                        r_cnt   <= '0;
                        r_len   <= arlen;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rdata <= ram_rd_data;
                            r_idx <= r_idx_nxt;
                            r_cnt <= r_cnt + 8'd1;
                            rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
